// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer driving external combinational pointDouble/pointAddition units.
// Latency: DONE reached 1+m+(popcount(k)-1) edges after accepted start (1 edge for k==0 or k==1).
// Backpressure: none; start is accepted only in IDLE, otherwise dropped. Optional SCALAR_MULT_NEG_EN adds neg.
`timescale 1ns/1ps
module scalar_mult_ctrl #(
    parameter int N = 3,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] k,
    input  logic [N-1:0] X0,
    input  logic [N-1:0] Y0,
    input  logic [N-1:0] Z0,
`ifdef SCALAR_MULT_NEG_EN
    input  logic         neg,
`endif
    output logic [N-1:0] dbl_X,
    output logic [N-1:0] dbl_Y,
    output logic [N-1:0] dbl_Z,
    input  logic [N-1:0] dbl_X2,
    input  logic [N-1:0] dbl_Y2,
    input  logic [N-1:0] dbl_Z2,
    output logic [N-1:0] add_X0,
    output logic [N-1:0] add_Y0,
    output logic [N-1:0] add_Z0,
    output logic [N-1:0] add_X1,
    output logic [N-1:0] add_Y1,
    output logic [N-1:0] add_Z1,
    input  logic [N-1:0] add_X2,
    input  logic [N-1:0] add_Y2,
    input  logic [N-1:0] add_Z2,
    output logic [N-1:0] X1,
    output logic [N-1:0] Y1,
    output logic [N-1:0] Z1,
    output logic         busy,
    output logic         done,
    output logic         result_inf
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] z;
    } pt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DBL,
        S_ADD,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    pt_t           acc, acc_nxt;
    pt_t           p_reg;
    pt_t           q_reg;
    pt_t           dbl_res, add_res;
    logic [K-1:0]  k_reg;
    logic [IW-1:0] idx, idx_nxt;
    logic [IW-1:0] msb_idx;
    logic          k_zero;
    logic          take;
    logic          inf_reg;
    logic [N-1:0]  fin_y;

    assign dbl_res = {dbl_X2, dbl_Y2, dbl_Z2};
    assign add_res = {add_X2, add_Y2, add_Z2};
    assign k_zero  = ~|k_reg;

    always_comb begin
        msb_idx = '0;
        for (int b = 0; b < K; b++) begin
            if (k_reg[b]) msb_idx = IW'(b);
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        idx_nxt   = idx;
        take      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    take      = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_nxt = p_reg;
                if (k_zero || msb_idx == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = msb_idx - 1'b1;
                    state_nxt = S_DBL;
                end
            end
            S_DBL: begin
                acc_nxt = dbl_res;
                if (k_reg[idx]) begin
                    state_nxt = S_ADD;
                end else if (idx == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt = idx - 1'b1;
                end
            end
            S_ADD: begin
                acc_nxt = add_res;
                if (idx == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = idx - 1'b1;
                    state_nxt = S_DBL;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef SCALAR_MULT_NEG_EN
    logic neg_reg;
    assign fin_y = neg_reg ? (acc_nxt.x ^ acc_nxt.y) : acc_nxt.y;
`else
    assign fin_y = acc_nxt.y;
`endif

    // Q is captured on the edge into DONE so it is already valid while done is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            acc     <= '0;
            p_reg   <= '0;
            k_reg   <= '0;
            idx     <= '0;
            q_reg   <= '{x: N'(1), y: '0, z: '0};
            inf_reg <= 1'b1;
`ifdef SCALAR_MULT_NEG_EN
            neg_reg <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            idx   <= idx_nxt;
            if (take) begin
                k_reg <= k;
                p_reg <= {X0, Y0, Z0};
`ifdef SCALAR_MULT_NEG_EN
                neg_reg <= neg;
`endif
            end
            if (state_nxt == S_DONE) begin
                inf_reg <= k_zero;
                if (k_zero) begin
                    q_reg <= '{x: N'(1), y: '0, z: '0};
                end else begin
                    q_reg <= '{x: acc_nxt.x, y: fin_y, z: acc_nxt.z};
                end
            end
        end
    end

    assign dbl_X      = acc.x;
    assign dbl_Y      = acc.y;
    assign dbl_Z      = acc.z;
    assign add_X0     = acc.x;
    assign add_Y0     = acc.y;
    assign add_Z0     = acc.z;
    assign add_X1     = p_reg.x;
    assign add_Y1     = p_reg.y;
    assign add_Z1     = p_reg.z;
    assign X1         = q_reg.x;
    assign Y1         = q_reg.y;
    assign Z1         = q_reg.z;
    assign result_inf = inf_reg;
    assign busy       = (state == S_LOAD) || (state == S_DBL) || (state == S_ADD);
    assign done       = (state == S_DONE);

endmodule
